// File: rtl/alu_exec_pkg.sv
// Shared types for the execute-stage ALU: operation codes (also used by the
// ALU control decoder), FSM state encoding and the default datapath width.
package alu_exec_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter used by alu_exec_unit when the
// ALU_EXEC_SHIFT_EN build option is defined.
module alu_shift_iter
    import alu_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  alu_op_e                  op,
    input  logic [XLEN-1:0]          operand,
    input  logic [$clog2(XLEN)-1:0]  amount,
    output logic                     done,
    output logic [XLEN-1:0]          value
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] sreg;
    logic [XLEN-1:0] shifted;
    logic [SHW-1:0]  count;
    alu_op_e         op_q;
    logic            busy;

    always_comb begin
        shifted = {1'b0, sreg[XLEN-1:1]};
        case (op_q)
            OP_SLL:  shifted = {sreg[XLEN-2:0], 1'b0};
            OP_SRA:  shifted = {sreg[XLEN-1], sreg[XLEN-1:1]};
            default: shifted = {1'b0, sreg[XLEN-1:1]};
        endcase
    end

    // The strobe fires on the cycle that performs the final shift, so the
    // parent registers `value` directly on that edge.
    assign done  = busy && (count == SHW'(1));
    assign value = shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            count <= '0;
            op_q  <= OP_AND;
            busy  <= 1'b0;
        end else if (start) begin
            sreg  <= operand;
            count <= amount;
            op_q  <= op;
            busy  <= 1'b1;
        end else if (busy) begin
            sreg  <= shifted;
            count <= count - SHW'(1);
            if (count == SHW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU with registered result, zero and illegal flags.
// Build option ALU_EXEC_SHIFT_EN enables iterative SLL/SRL/SRA; otherwise they decode as illegal.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ctrl_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]      state;
    logic            accept;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic            shift_launch;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

`ifdef ALU_EXEC_SHIFT_EN
    localparam int SHW = $clog2(XLEN);

    logic            shift_done;
    logic [XLEN-1:0] shift_value;

    alu_shift_iter #(
        .XLEN (XLEN)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && shift_launch),
        .op      (alu_op_e'(ctrl_i)),
        .operand (a_i),
        .amount  (b_i[SHW-1:0]),
        .done    (shift_done),
        .value   (shift_value)
    );
`endif

    // A zero-amount shift is a plain pass-through and completes in one cycle.
    always_comb begin
        alu_result   = '0;
        alu_illegal  = 1'b0;
        shift_launch = 1'b0;
        case (ctrl_i)
            OP_AND: alu_result = a_i & b_i;
            OP_OR:  alu_result = a_i | b_i;
            OP_ADD: alu_result = a_i + b_i;
            OP_SUB: alu_result = a_i - b_i;
            OP_XOR: alu_result = a_i ^ b_i;
            OP_SLT: alu_result = XLEN'($signed(a_i) < $signed(b_i));
`ifdef ALU_EXEC_SHIFT_EN
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_result   = a_i;
                shift_launch = (b_i[SHW-1:0] != '0);
            end
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            result_o  <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            case (state)
`ifdef ALU_EXEC_SHIFT_EN
                ST_SHIFT: begin
                    if (shift_done) begin
                        state     <= ST_DONE;
                        result_o  <= shift_value;
                        zero_o    <= (shift_value == '0);
                        illegal_o <= 1'b0;
                    end
                end
`endif
                default: begin
                    if (accept) begin
                        if (shift_launch) begin
                            state <= ST_SHIFT;
                        end else begin
                            state     <= ST_DONE;
                            result_o  <= alu_result;
                            zero_o    <= (alu_result == '0);
                            illegal_o <= alu_illegal;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table through a scoreboard
// plus latency, backpressure and mid-operation reset sequences.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ctrl_i = 4'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl_i    (ctrl_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic ill);
        return {r, (r == 32'd0), ill};
    endfunction

    // Expected shift outcome depends on whether the shifter is built in.
    function automatic exp_t shift_exp(input logic [31:0] r);
`ifdef ALU_EXEC_SHIFT_EN
        return mk(r, 1'b0);
`else
        return mk(32'd0, 1'b1);
`endif
    endfunction

    function automatic int shift_lat(input int n);
`ifdef ALU_EXEC_SHIFT_EN
        return (n == 0) ? 1 : n + 1;
`else
        return 1;
`endif
    endfunction

    task automatic add_vec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        vecs.push_back('{c, a, b, e});
    endtask

    // Offers one op; returns #1 after the accepting edge with inputs scrambled.
    task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input exp_t e, input bit push, output int waited);
        waited = 0;
        ctrl_i = c;
        a_i = a;
        b_i = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, required 1 within 100 cycles");
        end else if (push) begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        ctrl_i = 4'($urandom);
    endtask

    task automatic measure_latency(input string name, input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input exp_t e, input int exp_lat);
        int lat = 0;
        int waited;
        logic seen_ready = 1'b0;
        out_ready = 1'b1;
        applyStimulus(c, a, b, e, 1'b1, waited);
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) seen_ready = 1'b1;
        end while (!out_valid && lat < 64);
        checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (exp_lat > 1) checkOutput({name, "_busy_in_ready"}, 32'(seen_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, "_drained_pending"}, 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compares every completed output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got result 0x%08h, required no output", result_o);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("result", result_o, mon_e.result);
                checkOutput("zero", 32'(zero_o), 32'(mon_e.zero));
                checkOutput("illegal", 32'(illegal_o), 32'(mon_e.illegal));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int stale;

        add_vec(OP_ADD, 32'd5,          32'd7,          mk(32'd12, 1'b0));
        add_vec(OP_SUB, 32'd3,          32'd3,          mk(32'd0, 1'b0));
        add_vec(OP_SUB, 32'd0,          32'd1,          mk(32'hFFFF_FFFF, 1'b0));
        add_vec(OP_SLT, 32'hFFFF_FFFF,  32'd1,          mk(32'd1, 1'b0));
        add_vec(OP_SLT, 32'd1,          32'hFFFF_FFFF,  mk(32'd0, 1'b0));
        add_vec(OP_SLT, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  mk(32'd1, 1'b0));
        add_vec(OP_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  mk(32'hF000_F000, 1'b0));
        add_vec(OP_OR,  32'h0F0F_0000,  32'h0000_00F0,  mk(32'h0F0F_00F0, 1'b0));
        add_vec(OP_XOR, 32'hAAAA_5555,  32'hFFFF_0000,  mk(32'h5555_5555, 1'b0));
        add_vec(OP_ADD, 32'hFFFF_FFFF,  32'd2,          mk(32'd1, 1'b0));
        add_vec(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0,  mk(32'd0, 1'b1));
        add_vec(4'b0100, 32'h0000_0001, 32'h0000_0001,  mk(32'd0, 1'b1));
        add_vec(OP_SLL, 32'h0000_1234,  32'd0,          shift_exp(32'h0000_1234));
        add_vec(OP_SRA, 32'h8000_0000,  32'd4,          shift_exp(32'hF800_0000));
        add_vec(OP_SRA, 32'h7FFF_FFF0,  32'd4,          shift_exp(32'h07FF_FFFF));
        add_vec(OP_SLL, 32'h0000_0001,  32'd31,         shift_exp(32'h8000_0000));
        add_vec(OP_SRL, 32'h8000_0000,  32'd31,         shift_exp(32'h0000_0001));
        add_vec(OP_SRL, 32'hF000_0000,  32'h0000_0104,  shift_exp(32'h0F00_0000));

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", result_o, 32'd0);
        checkOutput("reset_zero", 32'(zero_o), 32'd0);
        checkOutput("reset_illegal", 32'(illegal_o), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        measure_latency("add", OP_ADD, 32'd5, 32'd7, mk(32'd12, 1'b0), 1);
        measure_latency("sra4", OP_SRA, 32'h8000_0000, 32'd4, shift_exp(32'hF800_0000), shift_lat(4));
        measure_latency("sll0", OP_SLL, 32'hCAFE_F00D, 32'd0, shift_exp(32'hCAFE_F00D), shift_lat(0));
        measure_latency("sll31", OP_SLL, 32'h0000_0003, 32'd31, shift_exp(32'h8000_0000), shift_lat(31));
        measure_latency("illegal", 4'b1111, 32'd9, 32'd9, mk(32'd0, 1'b1), 1);

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, waited);
        end
        drain("table");

        // Backpressure: result must hold while downstream stalls.
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 32'd10, 32'd20, mk(32'd30, 1'b0), 1'b1, waited);
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_result", result_o, 32'd30);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(OP_XOR, 32'h0000_FFFF, 32'h00FF_00FF, mk(32'h00FF_FF00, 1'b0), 1'b1, waited);
        checkOutput("bp_same_cycle_accept_wait", 32'(waited), 32'd0);
        @(negedge clk);
        checkOutput("bp_next_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_next_result", result_o, 32'h00FF_FF00);
        @(posedge clk);
        #1;
        drain("backpressure");

        // Reset mid-operation: the in-flight op must vanish.
        out_ready = 1'b0;
        applyStimulus(OP_SRL, 32'hFFFF_0000, 32'd20, mk(32'd0, 1'b0), 1'b0, waited);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_result", result_o, 32'd0);
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mid_illegal", 32'(illegal_o), 32'd0);
        out_ready = 1'b1;
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("rst_mid_stale_outputs", 32'(stale), 32'd0);
        checkOutput("final_pending", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
